// File: rtl/shift_rotate_pkg.sv
// Shared types for the shift/rotate register: operation codes and FSM states.
package shift_rotate_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'b000,
        SLL  = 3'b001,
        SRL  = 3'b010,
        SRA  = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        NOP  = 3'b110,
        RSVD = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic is_shift_op(op_t o);
        return (o == SLL) || (o == SRL) || (o == SRA) || (o == ROL) || (o == ROR);
    endfunction

endpackage

// File: rtl/shift_rotate_step.sv
// One-bit shift/rotate step, purely combinational.
// The shifted-out bit port exists only when SHIFT_ROTATE_UNIT_CARRY_EN is defined.
module shift_rotate_step
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_t              op,
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
    output logic             shift_out,
`endif
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
        shift_out = 1'b0;
`endif
        case (op)
            SLL: begin
                q_next = {q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
                shift_out = q[WIDTH-1];
`endif
            end
            SRL: begin
                q_next = {1'b0, q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
                shift_out = q[0];
`endif
            end
            SRA: begin
                q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
                shift_out = q[0];
`endif
            end
            ROL: begin
                q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
                shift_out = q[WIDTH-1];
`endif
            end
            ROR: begin
                q_next = {q[0], q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
                shift_out = q[0];
`endif
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate register, one bit position per clock, start/ready/done handshake.
// Define SHIFT_ROTATE_UNIT_CARRY_EN to implement the carry register; otherwise carry is tied to 0.
module shift_rotate_unit
    import shift_rotate_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic             carry
);

    state_t           state, state_d;
    op_t              op_q;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] step_q;
    op_t              op_in;
    logic             accept;

    assign op_in  = op_t'(op);
    assign accept = (state == IDLE) && start;

`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
    logic step_out;
    logic carry_q;

    shift_rotate_step #(.WIDTH(WIDTH)) u_step (
        .q         (Q),
        .op        (op_q),
        .shift_out (step_out),
        .q_next    (step_q)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            carry_q <= 1'b0;
        end else if (accept && (op_in == LOAD)) begin
            carry_q <= 1'b0;
        end else if (state == SHIFT) begin
            carry_q <= step_out;
        end
    end

    assign carry = carry_q;
`else
    shift_rotate_step #(.WIDTH(WIDTH)) u_step (
        .q      (Q),
        .op     (op_q),
        .q_next (step_q)
    );

    assign carry = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // cnt == 1 at an edge means this is the final step
    always_comb begin
        state_d = state;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (is_shift_op(op_in) && (amount != '0)) state_d = SHIFT;
                    else                                       state_d = DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == AW'(1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            Q    <= '0;
            cnt  <= '0;
            op_q <= NOP;
        end else if (accept) begin
            op_q <= op_in;
            cnt  <= amount;
            if (op_in == LOAD) Q <= data_in;
        end else if (state == SHIFT) begin
            Q   <= step_q;
            cnt <= cnt - AW'(1);
        end
    end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit (WIDTH=8): directed cases then random transactions.
module tb_shift_rotate_unit;
    import shift_rotate_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         resetn;
    logic         start;
    logic [2:0]   op;
    logic [2:0]   amount;
    logic [W-1:0] data_in;
    logic         ready, busy, done, carry;
    logic [W-1:0] Q;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_q = '0;
    logic         model_c = 1'b0;

    always #5 clock = ~clock;

    shift_rotate_unit #(.WIDTH(W)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .data_in (data_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .Q       (Q),
        .carry   (carry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_carry(input logic c);
`ifdef SHIFT_ROTATE_UNIT_CARRY_EN
        return c;
`else
        return 1'b0;
`endif
    endfunction

    // Result of applying a k-position shift/rotate to q, computed in one go.
    function automatic logic [W:0] ref_shift(input logic [2:0] o, input logic [W-1:0] q,
                                             input int k, input logic c_in);
        logic [W-1:0] r;
        logic         c;
        r = q;
        c = c_in;
        if (k > 0) begin
            case (o)
                3'd1: begin r = q << k;                    c = q[W-k];   end
                3'd2: begin r = q >> k;                    c = q[k-1];   end
                3'd3: begin r = W'($signed(q) >>> k);      c = q[k-1];   end
                3'd4: begin r = (q << k) | (q >> (W-k));   c = r[0];     end
                3'd5: begin r = (q >> k) | (q << (W-k));   c = r[W-1];   end
                default: ;
            endcase
        end
        return {c, r};
    endfunction

    task automatic do_op(input logic [2:0] o, input int amt, input logic [W-1:0] din, input bit hold);
        int           w;
        bit           shifting;
        logic [W-1:0] q0;
        logic         c0;
        logic [W:0]   r;
        w = 0;
        while (!ready && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        check("ready_before_start", ready, 1);
        start   = 1'b1;
        op      = o;
        amount  = amt[2:0];
        data_in = din;
        @(posedge clock); #1;
        if (hold) begin
            op      = 3'd0;
            data_in = W'($urandom);
            amount  = 3'($urandom);
        end else begin
            start   = 1'b0;
            op      = 3'($urandom);
            data_in = W'($urandom);
        end
        shifting = (o >= 3'd1) && (o <= 3'd5) && (amt > 0);
        if (o == 3'd0) begin
            model_q = din;
            model_c = 1'b0;
        end
        q0 = model_q;
        c0 = model_c;
        if (shifting) begin
            for (int k = 1; k <= amt; k++) begin
                check("busy_during_shift", {busy, done, ready}, 3'b100);
                @(posedge clock); #1;
                r = ref_shift(o, q0, k, c0);
                check("q_step", Q, r[W-1:0]);
            end
            r = ref_shift(o, q0, amt, c0);
            model_q = r[W-1:0];
            model_c = r[W];
        end
        check("done_pulse", {done, busy, ready}, 3'b100);
        check("q_final", Q, model_q);
        check("carry_final", carry, exp_carry(model_c));
        start = 1'b0;
        @(posedge clock); #1;
        check("done_cleared_ready_back", {done, ready}, 2'b01);
        check("q_hold_after_done", Q, model_q);
    endtask

    initial begin
        int  seen_done;
        bit  hold;
        int  o, a;
        resetn  = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        amount  = 3'd0;
        data_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {Q, carry, ready, busy, done}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        do_op(3'd0, 0, 8'hA5, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("async_reset", {Q, carry, ready, busy, done}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        model_q = '0;
        model_c = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        do_op(3'd0, 0, 8'h81, 1'b0);
        do_op(3'd3, 3, 8'h00, 1'b0);
        check("sra3_result", Q, 8'hF0);
        do_op(3'd0, 0, 8'h81, 1'b0);
        do_op(3'd4, 1, 8'h00, 1'b0);
        check("rol1_result", {carry, Q}, {exp_carry(1'b1), 8'h03});
        do_op(3'd0, 0, 8'h01, 1'b0);
        do_op(3'd5, 7, 8'h00, 1'b0);
        check("ror7_result", {carry, Q}, {1'b0, 8'h02});
        do_op(3'd0, 0, 8'hF0, 1'b0);
        do_op(3'd2, 4, 8'h00, 1'b0);
        check("srl4_result", {carry, Q}, {1'b0, 8'h0F});
        do_op(3'd0, 0, 8'h81, 1'b0);
        do_op(3'd4, 1, 8'h00, 1'b0);
        do_op(3'd0, 0, 8'h3C, 1'b0);
        do_op(3'd1, 0, 8'h00, 1'b0);
        check("sll0_result", Q, 8'h3C);
        do_op(3'd0, 0, 8'h3C, 1'b0);
        do_op(3'd4, 3, 8'h00, 1'b0);
        do_op(3'd1, 0, 8'h00, 1'b0);
        check("sll0_carry_kept", carry, exp_carry(1'b1));
        do_op(3'd2, 5, 8'h00, 1'b1);
        do_op(3'd6, 3, 8'hFF, 1'b0);
        do_op(3'd7, 2, 8'hFF, 1'b0);

        do_op(3'd0, 0, 8'h5A, 1'b0);
        start  = 1'b1;
        op     = 3'd4;
        amount = 3'd5;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("busy_before_mid_reset", busy, 1);
        resetn = 1'b0;
        #1;
        check("mid_shift_reset", {Q, carry, ready, busy, done}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        model_q = '0;
        model_c = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (done) seen_done++;
        end
        check("no_done_after_reset", seen_done, 0);
        check("q_zero_after_reset", Q, 8'h00);

        for (int t = 0; t < 80; t++) begin
            o    = $urandom_range(0, 7);
            a    = $urandom_range(0, 7);
            hold = ($urandom_range(0, 3) == 0);
            do_op(3'(o), a, W'($urandom), hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/shift_rotate_unit.md
# shift_rotate_unit

Parametrised, multi-cycle shift/rotate register: the WIDTH-bit generalisation of the lab's 8-bit rotate/ASR shifter. It supports parallel load, logical and arithmetic shifts and rotates in both directions, by a programmable amount, through a start/ready/done handshake. It shifts one bit position per clock, so no barrel shifter is needed. It sits in the lab datapath wherever a register needs in-place shift/rotate, feeding results and an optional carry flag to downstream logic.

## Interface
- WIDTH, 8, register width; minimum 2.
- AW, $clog2(WIDTH), width of the amount field (derived; not overridden).
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when ready=1.
- op  in  3  operation code: 000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110 NOP, 111 reserved (treated as NOP).
- amount  in  AW  shift distance, 0..WIDTH-1; ignored for LOAD/NOP.
- data_in  in  WIDTH  parallel load value.
- ready  out  1  high only in IDLE.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle completion pulse.
- Q  out  WIDTH  register contents.
- carry  out  1  last bit shifted or rotated out.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: latch op and amount.
  - LOAD: Q<=data_in, carry<=0, go to DONE.
  - NOP/reserved: go to DONE; Q and carry unchanged.
  - Shift op with amount=0: go to DONE; Q and carry unchanged.
  - Shift op with amount>0: cnt<=amount, go to SHIFT.
- SHIFT: each edge applies one step to Q and decrements cnt. When cnt==1 at the edge, go to DONE.
- Step rules:
  - SLL: Q<={Q[W-2:0],0}
  - SRL: Q<={0,Q[W-1:1]}
  - SRA: Q<={Q[W-1],Q[W-1:1]}
  - ROL: Q<={Q[W-2:0],Q[W-1]}
  - ROR: Q<={Q[0],Q[W-1:1]}
- Carry per step: Q[W-1] for SLL/ROL; Q[0] for SRL/SRA/ROR (value before the step).
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE; op, amount and data_in are don't-care after acceptance.
- Reset: Q=0, carry=0, cnt=0, state=IDLE, so ready=1, busy=0, done=0. Reset asserted mid-operation clears all state immediately and discards the pending operation.

## Timing
- Acceptance at edge E0.
- Shift op with amount N>0: steps occur at E1..EN; done is high in the cycle after EN; ready returns after E(N+1). Occupancy is N+2 cycles.
- LOAD, NOP, or amount=0: done is high in the cycle after E0; ready returns after E1.
- Q and carry are registered outputs. They change only at step edges, at LOAD acceptance, or on reset.
- ready, busy and done decode directly from state; there is no combinational path from inputs.

## Configuration
- SHIFT_ROTATE_UNIT_CARRY_EN defined: the carry register is implemented and behaves as above.
- Not defined: no carry register; carry is tied to 0. All other behaviour is identical.

## Structure
- Package shift_rotate_pkg holds:
  - op_t enum: LOAD, SLL, SRL, SRA, ROL, ROR, NOP, RSVD.
  - state_t enum: IDLE, SHIFT, DONE.
- Sub-module shift_rotate_step is purely combinational. It takes (Q, op) and produces the next Q and the shifted-out bit. The top level holds the FSM, cnt, Q and carry registers.

## Test plan
- Reset: drive resetn=0 with Q previously 0xA5 -> Q=0x00, carry=0, ready=1, busy=0, done=0 without waiting for a clock edge.
- LOAD: op=LOAD, data_in=0xA5 -> Q=0xA5 one edge after acceptance; done pulses for exactly one cycle; ready returns 2 cycles after acceptance.
- SRA 3 from 0x81 -> Q sequence 0xC0, 0xE0, 0xF0; final carry=0; busy high for 3 cycles; done follows.
- Rotates:
  - ROL 1 from 0x81 -> Q=0x03, carry=1.
  - ROR 7 from 0x01 -> Q=0x02, carry=0.
  - SRL 4 from 0xF0 -> Q=0x0F, carry=0.
- Edge cases:
  - SLL with amount=0 from 0x3C -> Q=0x3C, carry unchanged, done the cycle after acceptance.
  - start held high with op=LOAD during a busy SRL -> ignored; the SRL result is unaffected.
- Reset mid-SHIFT: resetn low during a ROL 5 -> Q=0, state IDLE immediately; no done pulse after release.
